// File: rtl/activation_cache_assoc_pkg.sv
// Shared types and address helpers for the set-associative activation cache.
package activation_cache_pkg;

  // Widest address the helpers handle; callers size-cast the result down.
  localparam int ADDR_MAX = 64;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_FLUSH   = 2'b10,
    OP_ILLEGAL = 2'b11
  } cache_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    FLUSH  = 2'b10,
    RESP   = 2'b11
  } cache_state_t;

  // Set index lives in the low set_w address bits.
  function automatic logic [ADDR_MAX-1:0] set_of(input logic [ADDR_MAX-1:0] addr,
                                                 input int set_w);
    logic [ADDR_MAX-1:0] mask;
    mask = (ADDR_MAX'(1) << set_w) - ADDR_MAX'(1);
    return addr & mask;
  endfunction

  // Tag is everything above the set index.
  function automatic logic [ADDR_MAX-1:0] tag_of(input logic [ADDR_MAX-1:0] addr,
                                                 input int set_w);
    return addr >> set_w;
  endfunction

endpackage

// File: rtl/activation_cache_assoc_victim.sv
// Way selection for one set: hit way, else lowest free way, else round-robin victim.
module cache_victim_picker
  import activation_cache_pkg::*;
#(
  parameter int NWAYS = 5,
  parameter int PTR_W = 3
) (
  input  logic [NWAYS-1:0] valid_i,   // per-way valid bits of the set
  input  logic [NWAYS-1:0] match_i,   // raw per-way tag equality
  input  logic [PTR_W-1:0] rr_ptr_i,  // set's replacement pointer
  output logic [PTR_W-1:0] way_o,
  output logic             hit_o,
  output logic             evict_o,
  output logic             ptr_adv_o
);

  logic [NWAYS-1:0] hit_vec;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] free_idx;
  logic             full;

  // A tag only counts when the way holds live data.
  assign hit_vec = valid_i & match_i;
  assign full    = &valid_i;

  // Priority encoders: scanning downward leaves the lowest index standing.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_idx  = PTR_W'(w);
      if (!valid_i[w]) free_idx = PTR_W'(w);
    end
  end

  // Hit beats fill; fill beats eviction. Only eviction moves the pointer.
  always_comb begin
    hit_o     = |hit_vec;
    evict_o   = !hit_o && full;
    ptr_adv_o = evict_o;
    if (hit_o)     way_o = hit_idx;
    else if (full) way_o = rr_ptr_i;
    else           way_o = free_idx;
  end

endmodule

// File: rtl/activation_cache_assoc.sv
// Set-associative activation cache: read/write-allocate/flush behind a valid/ready request port.
module activation_cache_assoc
  import activation_cache_pkg::*;
#(
  parameter int NWAYS         = 5,
  parameter int NSETS         = 256,
  parameter int ADDRESS_WIDTH = 21,
  parameter int WORD_SIZE     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]     req_wdata,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic                     resp_evict,
  output logic [WORD_SIZE-1:0]     resp_rdata,
  output logic                     error
);

  localparam int SET_WIDTH = $clog2(NSETS);
  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH;
  localparam int PTR_W     = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(NSETS - 1);
  localparam logic [PTR_W-1:0]     LAST_WAY = PTR_W'(NWAYS - 1);

  cache_state_t state_q, state_d;
  logic         ready_q, resp_valid_q, resp_hit_q, resp_evict_q, err_q;
  logic [WORD_SIZE-1:0] resp_rdata_q;
  logic [SET_WIDTH-1:0] cnt_q;

  // Request captured at the handshake; inputs are free to move afterwards.
  cache_op_t            op_q;
  logic [SET_WIDTH-1:0] set_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [WORD_SIZE-1:0] wdata_q;

  // Storage: valid/pointer need reset, tag/data do not.
  logic [NSETS-1:0][NWAYS-1:0] valid_q;
  logic [NSETS-1:0][PTR_W-1:0] rr_q;
  logic [TAG_WIDTH-1:0] tag_arr  [NWAYS][NSETS];
  logic [WORD_SIZE-1:0] data_arr [NWAYS][NSETS];

  logic             accept;
  logic [NWAYS-1:0] match;
  logic [PTR_W-1:0] pk_way, rr_next;
  logic             pk_hit, pk_evict, pk_adv;
  logic [WORD_SIZE-1:0] rd_word;

  assign accept = req_valid && ready_q && (state_q == IDLE);

  for (genvar w = 0; w < NWAYS; w++) begin : g_cmp
    assign match[w] = (tag_arr[w][set_q] == tag_q);
  end

  cache_victim_picker #(
    .NWAYS (NWAYS),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid_i   (valid_q[set_q]),
    .match_i   (match),
    .rr_ptr_i  (rr_q[set_q]),
    .way_o     (pk_way),
    .hit_o     (pk_hit),
    .evict_o   (pk_evict),
    .ptr_adv_o (pk_adv)
  );

  assign rd_word = data_arr[pk_way][set_q];
  assign rr_next = (rr_q[set_q] == LAST_WAY) ? '0 : rr_q[set_q] + PTR_W'(1);

  // Next-state: lookups take one cycle, flush walks every set once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (cache_op_t'(req_op) == OP_FLUSH) ? FLUSH : LOOKUP;
      LOOKUP:  state_d = RESP;
      FLUSH:   if (cnt_q == LAST_SET) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, response registers, valid bits and replacement pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_evict_q <= 1'b0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      // Response fields are zero unless a lookup just produced them.
      resp_hit_q   <= 1'b0;
      resp_evict_q <= 1'b0;
      resp_rdata_q <= '0;
      if (accept) cnt_q <= '0;
      if (state_q == LOOKUP) begin
        case (op_q)
          OP_READ: begin
            resp_hit_q   <= pk_hit;
            resp_rdata_q <= pk_hit ? rd_word : '0;
          end
          OP_WRITE: begin
            resp_hit_q             <= pk_hit;
            resp_evict_q           <= pk_evict;
            valid_q[set_q][pk_way] <= 1'b1;
            if (pk_adv) rr_q[set_q] <= rr_next;
          end
          OP_ILLEGAL: err_q <= 1'b1;
          default: ;
        endcase
      end
      if (state_q == FLUSH) begin
        valid_q[cnt_q] <= '0;
        rr_q[cnt_q]    <= '0;
        cnt_q          <= cnt_q + SET_WIDTH'(1);
      end
    end
  end

  // Request capture and tag/data writes; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= cache_op_t'(req_op);
      set_q   <= SET_WIDTH'(set_of(ADDR_MAX'(req_addr), SET_WIDTH));
      tag_q   <= TAG_WIDTH'(tag_of(ADDR_MAX'(req_addr), SET_WIDTH));
      wdata_q <= req_wdata;
    end
    if (state_q == LOOKUP && op_q == OP_WRITE) begin
      tag_arr[pk_way][set_q]  <= tag_q;
      data_arr[pk_way][set_q] <= wdata_q;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_evict = resp_evict_q;
  assign resp_rdata = resp_rdata_q;
  assign error      = err_q;

endmodule

// File: tb/tb_activation_cache_assoc.sv
// Random + directed bench for activation_cache_assoc against a per-set fill-order model.
module tb_activation_cache_assoc;
  localparam int NWAYS = 5;
  localparam int NSETS = 256;
  localparam int AW    = 21;
  localparam int WS    = 16;
  localparam int SW    = 8;
  localparam int TW    = AW - SW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [WS-1:0] req_wdata;
  logic          resp_valid, resp_hit, resp_evict, error;
  logic [WS-1:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  activation_cache_assoc #(
    .NWAYS(NWAYS), .NSETS(NSETS), .ADDRESS_WIDTH(AW), .WORD_SIZE(WS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_evict(resp_evict),
    .resp_rdata(resp_rdata), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each set is an ordered list of slots filled in way order; once
  // full, replacement walks the slots round-robin starting at slot 0.
  logic [TW-1:0] mtag [NSETS][NWAYS];
  logic [WS-1:0] mdat [NSETS][NWAYS];
  int            mcnt [NSETS];
  int            mrr  [NSETS];
  bit            merr;

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin mcnt[s] = 0; mrr[s] = 0; end
    merr = 1'b0;
  endtask

  task automatic model(input logic [1:0] op, input logic [AW-1:0] addr, input logic [WS-1:0] wd,
                       output bit eh, output bit ee, output logic [WS-1:0] ed);
    int s, hw;
    logic [TW-1:0] t;
    s  = int'(addr[SW-1:0]);
    t  = addr[AW-1:SW];
    eh = 1'b0; ee = 1'b0; ed = '0; hw = -1;
    for (int i = mcnt[s] - 1; i >= 0; i--) if (mtag[s][i] == t) hw = i;
    case (op)
      2'b00: if (hw >= 0) begin eh = 1'b1; ed = mdat[s][hw]; end
      2'b01: begin
        if (hw >= 0) begin
          eh = 1'b1; mdat[s][hw] = wd;
        end else if (mcnt[s] < NWAYS) begin
          mtag[s][mcnt[s]] = t; mdat[s][mcnt[s]] = wd; mcnt[s]++;
        end else begin
          ee = 1'b1; mtag[s][mrr[s]] = t; mdat[s][mrr[s]] = wd;
          mrr[s] = (mrr[s] + 1) % NWAYS;
        end
      end
      2'b10: for (int k = 0; k < NSETS; k++) begin mcnt[k] = 0; mrr[k] = 0; end
      default: merr = 1'b1;
    endcase
  endtask

  // One full transaction: handshake, latency, response fields, pulse width, ready return.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [WS-1:0] wd);
    bit eh, ee, busy_ok;
    logic [WS-1:0] ed;
    int w, lat, exp_lat;
    w = 0;
    while (!req_ready && w < NSETS + 10) begin @(negedge clk); w++; end
    chk("ready_wait", 32'(req_ready), 32'd1);
    model(op, addr, wd, eh, ee, ed);
    exp_lat = (op == 2'b10) ? NSETS + 1 : 2;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = AW'($urandom); req_wdata = WS'($urandom);
    lat = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk); lat++;
      if (req_ready) busy_ok = 1'b0;
    end while (!resp_valid && lat < exp_lat + 5);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_ready_low", 32'(busy_ok), 32'd1);
    chk("hit", 32'(resp_hit), 32'(eh));
    chk("evict", 32'(resp_evict), 32'(ee));
    chk("rdata", 32'(resp_rdata), 32'(ed));
    chk("error", 32'(error), 32'(merr));
    @(negedge clk);
    chk("pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [AW-1:0] mk(input int tg, input int st);
    return AW'((tg << SW) | st);
  endfunction

  initial begin
    int pool [4];
    bit bad;
    logic [1:0] op;
    pool = '{32'h10, 32'h11, 32'h00, 32'hFF};
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_hit", 32'(resp_hit), 32'd0);
    chk("rst_evict", 32'(resp_evict), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: miss, write/read, overwrite, fill and rotate set 0x10.
    do_req(2'b00, 21'h00010, '0);
    do_req(2'b01, 21'h00110, 16'hBEEF);
    do_req(2'b00, 21'h00110, '0);
    do_req(2'b01, 21'h00110, 16'h1234);
    do_req(2'b00, 21'h00110, '0);
    for (int t = 2; t <= 6; t++) do_req(2'b01, mk(t, 8'h10), WS'(16'hA000 + t));
    do_req(2'b00, mk(1, 8'h10), '0);
    do_req(2'b00, mk(6, 8'h10), '0);
    for (int t = 7; t <= 11; t++) do_req(2'b01, mk(t, 8'h10), WS'(16'hB000 + t));
    for (int t = 5; t <= 11; t++) do_req(2'b00, mk(t, 8'h10), '0);
    do_req(2'b01, mk(3, 8'h11), 16'h1111);
    do_req(2'b01, mk(4, 8'h20), 16'h2222);
    do_req(2'b00, mk(3, 8'h11), '0);

    // Flush, then everything misses and filling restarts from slot 0.
    do_req(2'b10, '0, '0);
    do_req(2'b00, mk(3, 8'h11), '0);
    do_req(2'b00, mk(11, 8'h10), '0);
    for (int t = 20; t <= 26; t++) do_req(2'b01, mk(t, 8'h10), WS'(t));

    // Illegal op sets a sticky error.
    do_req(2'b11, mk(20, 8'h10), '0);
    do_req(2'b00, mk(26, 8'h10), '0);

    // Random mix over a small address pool to force hits and evictions.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      op = (r < 45) ? 2'b00 : (r < 95) ? 2'b01 : (r < 98) ? 2'b10 : 2'b11;
      do_req(op, mk($urandom_range(0, 7), pool[$urandom_range(0, 3)]), WS'($urandom));
    end

    // Reset in the middle of a flush: aborted, no response, storage invalid.
    do_req(2'b01, mk(5, 8'hFF), 16'h5A5A);
    do_req(2'b11, '0, '0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bad = 1'b0;
    repeat (40) begin @(negedge clk); if (resp_valid) bad = 1'b1; end
    reset = 1'b1;
    @(negedge clk);
    chk("midflush_rst_ready", 32'(req_ready), 32'd0);
    chk("midflush_rst_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (NSETS + 5) begin @(negedge clk); if (resp_valid) bad = 1'b1; end
    chk("midflush_no_resp", 32'(bad), 32'd0);
    do_req(2'b00, mk(5, 8'hFF), '0);
    for (int p = 0; p < 4; p++) do_req(2'b00, mk($urandom_range(0, 7), pool[p]), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so a wedged design still produces a verdict.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
